// File: rtl/equiv_checker_if.sv
// Stimulus/response bundle between the equivalence checker and the two units under test.
// The checker is the master: it drives stim and samples both responses.
interface equiv_checker_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2
);
  logic [IN_W-1:0]  stim;
  logic             stim_valid;
  logic [OUT_W-1:0] resp_b;
  logic [OUT_W-1:0] resp_s;

  modport master (output stim, output stim_valid, input resp_b, input resp_s);
  modport slave  (input stim, input stim_valid, output resp_b, output resp_s);
endinterface

// File: rtl/equiv_checker.sv
// Drives LFSR vectors into a behavioural and a structural UUT and compares their
// responses LATENCY cycles later, counting mismatches and capturing the first failing index.
module equiv_checker #(
  parameter int IN_W         = 4,
  parameter int OUT_W        = 2,
  parameter int N_VECTORS    = 10,
  parameter int LATENCY      = 0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           seed,
  equiv_checker_if.master       uut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           mismatch_cnt,
  output logic [15:0]           first_fail_idx,
  output logic                  first_fail_valid
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LAST_IDX  = 16'(N_VECTORS - 1);

  state_t          state_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     issue_cnt_q;
  logic [15:0]     stim_idx_q;
  logic [IN_W-1:0] stim_q;
  logic            stim_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [15:0]     mismatch_cnt_q;
  logic [15:0]     first_fail_idx_q;
  logic            first_fail_valid_q;

  logic            cmp_vld;
  logic [15:0]     cmp_idx;
  logic            pipe_busy;
  logic            active;
  logic            mismatch;
  logic            abort;
  logic            flush;
  logic [15:0]     cnt_d;
  logic [15:0]     lfsr_d;

  always_comb begin
    active   = (state_q == RUN) || (state_q == DRAIN);
    mismatch = active && cmp_vld && (uut.resp_b != uut.resp_s);
    abort    = STOP_ON_FAIL && mismatch;
    flush    = (start && !active) || abort;
    cnt_d    = mismatch_cnt_q;
    if (mismatch && (mismatch_cnt_q != 16'hFFFF)) begin
      cnt_d = mismatch_cnt_q + 16'd1;
    end
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
  end

  // pipe_busy: some vector will still be compared after the coming edge.
  generate
    if (LATENCY == 0) begin : g_nolat
      assign cmp_vld   = stim_valid_q;
      assign cmp_idx   = stim_idx_q;
      assign pipe_busy = 1'b0;
    end else begin : g_lat
      logic [LATENCY-1:0] vld_q;
      logic [15:0]        idx_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY; i++) idx_q[i] <= '0;
        end else begin
          if (flush) begin
            vld_q <= '0;
          end else begin
            vld_q[0] <= stim_valid_q;
            for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
          end
          idx_q[0] <= stim_idx_q;
          for (int i = 1; i < LATENCY; i++) idx_q[i] <= idx_q[i-1];
        end
      end

      assign cmp_vld   = vld_q[LATENCY-1];
      assign cmp_idx   = idx_q[LATENCY-1];
      assign pipe_busy = stim_valid_q | (|(vld_q << 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      lfsr_q             <= LFSR_INIT;
      issue_cnt_q        <= '0;
      stim_idx_q         <= '0;
      stim_q             <= '0;
      stim_valid_q       <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      mismatch_cnt_q     <= '0;
      first_fail_idx_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      if (mismatch) begin
        mismatch_cnt_q <= cnt_d;
        if (!first_fail_valid_q) begin
          first_fail_idx_q   <= cmp_idx;
          first_fail_valid_q <= 1'b1;
        end
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lfsr_q             <= (seed == 16'h0000) ? LFSR_INIT : seed;
            issue_cnt_q        <= '0;
            stim_idx_q         <= '0;
            mismatch_cnt_q     <= '0;
            first_fail_idx_q   <= '0;
            first_fail_valid_q <= 1'b0;
            pass_q             <= 1'b0;
            done_q             <= 1'b0;
            busy_q             <= 1'b1;
            state_q            <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= (cnt_d == 16'd0);
            state_q      <= DONE;
          end else begin
            stim_q       <= lfsr_q[IN_W-1:0];
            stim_valid_q <= 1'b1;
            stim_idx_q   <= issue_cnt_q;
            issue_cnt_q  <= issue_cnt_q + 16'd1;
            lfsr_q       <= lfsr_d;
            if (issue_cnt_q == LAST_IDX) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          stim_valid_q <= 1'b0;
          if (abort || !pipe_busy) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (cnt_d == 16'd0);
            state_q <= DONE;
          end
        end
      endcase
    end
  end

  assign uut.stim         = stim_q;
  assign uut.stim_valid   = stim_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = mismatch_cnt_q;
  assign first_fail_idx   = first_fail_idx_q;
  assign first_fail_valid = first_fail_valid_q;
endmodule

// File: tb/tb_equiv_checker.sv
// Bench for equiv_checker: three instances (plain, LATENCY=3, STOP_ON_FAIL=1) checked
// against an LFSR reference model and a fault-mask driven pair of UUT response models.
module tb_equiv_checker;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a  [3];
  logic [15:0] seed_a   [3];
  logic [31:0] fmask_a  [3];
  logic [3:0]  stim_a   [3];
  logic        sv_a     [3];
  logic        busy_a   [3];
  logic        done_a   [3];
  logic        pass_a   [3];
  logic        ffv_a    [3];
  logic [15:0] cnt_a    [3];
  logic [15:0] ffi_a    [3];

  int n_tests = 0;
  int n_fail  = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 1) ? 3 : 0;
      localparam bit SOF = (gi == 2);

      equiv_checker_if #(.IN_W(4), .OUT_W(2)) u_if ();

      equiv_checker #(
        .IN_W(4), .OUT_W(2), .N_VECTORS(N), .LATENCY(LAT), .STOP_ON_FAIL(SOF)
      ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_a[gi]),
        .seed             (seed_a[gi]),
        .uut              (u_if),
        .busy             (busy_a[gi]),
        .done             (done_a[gi]),
        .pass             (pass_a[gi]),
        .mismatch_cnt     (cnt_a[gi]),
        .first_fail_idx   (ffi_a[gi]),
        .first_fail_valid (ffv_a[gi])
      );

      assign stim_a[gi] = u_if.stim;
      assign sv_a[gi]   = u_if.stim_valid;

      // UUT pair model: responses for vector k appear LAT cycles after it was driven;
      // outside a compare slot the responses deliberately disagree.
      bit hv [16];
      int hi [16];
      int vcnt = 0;
      always @(negedge clk) begin
        logic [1:0] rb;
        for (int i = 15; i > 0; i--) begin
          hv[i] = hv[i-1];
          hi[i] = hi[i-1];
        end
        if (!busy_a[gi]) vcnt = 0;
        hv[0] = u_if.stim_valid;
        hi[0] = vcnt;
        if (u_if.stim_valid) vcnt++;
        rb = 2'($urandom);
        u_if.resp_b = rb;
        if (!hv[LAT])                      u_if.resp_s = ~rb;
        else if (fmask_a[gi][hi[LAT] % 32]) u_if.resp_s = rb ^ 2'($urandom_range(1, 3));
        else                               u_if.resp_s = rb;
      end
    end
  endgenerate

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic run_check(input int d, input logic [15:0] seed, input logic [31:0] mask,
                           input int repulse, input string name);
    logic [15:0] v;
    logic [3:0]  exp_stim [$];
    int lat, first_f, exp_cnt, exp_pulses, exp_done, pulses, cyc, done_cyc;
    bit sof;
    lat = (d == 1) ? 3 : 0;
    sof = (d == 2);
    v = (seed == 16'h0000) ? 16'hACE1 : seed;
    for (int k = 0; k < N; k++) begin
      exp_stim.push_back(v[3:0]);
      v = lfsr_step(v);
    end
    first_f = -1;
    exp_cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        if (first_f < 0) first_f = k;
        exp_cnt++;
      end
    end
    if (sof && first_f >= 0) begin
      exp_cnt = 1; exp_pulses = first_f + 1; exp_done = first_f + 2;
    end else begin
      exp_pulses = N; exp_done = N + lat + 1;
    end
    fmask_a[d] = mask;
    seed_a[d]  = seed;
    @(posedge clk); #1 start_a[d] = 1'b1;
    @(posedge clk); #1 start_a[d] = 1'b0;
    n_tests++;
    if (busy_a[d] !== 1'b1 || done_a[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_start: busy=%b done=%b required busy=1 done=0", name, busy_a[d], done_a[d]);
    end
    pulses = 0; done_cyc = -1; cyc = 0;
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start_a[d] = (cyc == repulse);
      if (sv_a[d]) begin
        n_tests++;
        if (pulses >= N) begin
          n_fail++;
          $display("FAIL %s extra_vector: vector %0d issued, required at most %0d", name, pulses, N);
        end else if (stim_a[d] !== exp_stim[pulses]) begin
          n_fail++;
          $display("FAIL %s stim[%0d]: got 0x%h required 0x%h", name, pulses, stim_a[d], exp_stim[pulses]);
        end
        pulses++;
      end
      if (done_a[d]) done_cyc = cyc;
    end
    start_a[d] = 1'b0;
    n_tests++;
    if (done_cyc != exp_done) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end
    n_tests++;
    if (pulses != exp_pulses) begin
      n_fail++;
      $display("FAIL %s pulses: got %0d required %0d", name, pulses, exp_pulses);
    end
    n_tests++;
    if (cnt_a[d] !== 16'(exp_cnt) || pass_a[d] !== (exp_cnt == 0) ||
        ffv_a[d] !== (first_f >= 0) || ffi_a[d] !== ((first_f >= 0) ? 16'(first_f) : 16'd0)) begin
      n_fail++;
      $display("FAIL %s result: cnt=%0d pass=%b ffv=%b ffi=%0d required cnt=%0d pass=%b ffv=%b ffi=%0d",
               name, cnt_a[d], pass_a[d], ffv_a[d], ffi_a[d], exp_cnt, exp_cnt == 0,
               first_f >= 0, (first_f >= 0) ? first_f : 0);
    end
    n_tests++;
    if (busy_a[d] !== 1'b0 || sv_a[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_at_done: busy=%b stim_valid=%b required 0 0", name, busy_a[d], sv_a[d]);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done_a[d] !== 1'b1 || cnt_a[d] !== 16'(exp_cnt) || pass_a[d] !== (exp_cnt == 0)) begin
      n_fail++;
      $display("FAIL %s hold: done=%b cnt=%0d pass=%b required done=1 cnt=%0d pass=%b",
               name, done_a[d], cnt_a[d], pass_a[d], exp_cnt, exp_cnt == 0);
    end
    $display("[TB] %s dut=%0d seed=0x%h mask=0x%h vectors=%0d done@%0d cnt=%0d first=%0d",
             name, d, seed, mask[9:0], pulses, done_cyc, cnt_a[d], ffi_a[d]);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({stim_a[d], sv_a[d], busy_a[d], done_a[d], pass_a[d], ffv_a[d], cnt_a[d], ffi_a[d]} !== 40'd0) begin
        n_fail++;
        $display("FAIL reset_state dut=%0d: stim=%h sv=%b busy=%b done=%b pass=%b ffv=%b cnt=%0d ffi=%0d required all zero",
                 d, stim_a[d], sv_a[d], busy_a[d], done_a[d], pass_a[d], ffv_a[d], cnt_a[d], ffi_a[d]);
      end
    end
    $display("[TB] reset state checked on 3 instances");
  endtask

  task automatic test_basic();
    run_check(0, 16'h0001, 32'h0, -1, "basic");
  endtask

  task automatic test_latency();
    run_check(1, 16'h0001, 32'h8, -1, "latency3_fail_v3");
  endtask

  task automatic test_seed_zero();
    run_check(0, 16'h0000, 32'h0, -1, "seed_zero");
  endtask

  task automatic test_stop_on_fail();
    run_check(2, 16'(($urandom % 16'hFFFF) + 1), 32'h24, -1, "stop_on_fail_v2");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int d;
      logic [31:0] m;
      d = $urandom_range(0, 2);
      m = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'h3FF);
      run_check(d, 16'($urandom), m, -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_check(1, 16'hBEEF, 32'h201, -1, "b2b_first");
    run_check(1, 16'h1234, 32'h0, -1, "b2b_second");
  endtask

  task automatic test_restart_ignored();
    run_check(0, 16'h5A5A, 32'h10, 4, "restart_ignored");
  endtask

  task automatic test_reset_midrun();
    bit bad;
    seed_a[0]  = 16'h0F0F;
    fmask_a[0] = 32'h3;
    @(posedge clk); #1 start_a[0] = 1'b1;
    @(posedge clk); #1 start_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({stim_a[0], sv_a[0], busy_a[0], done_a[0], pass_a[0], ffv_a[0], cnt_a[0], ffi_a[0]} !== 40'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: stim=%h sv=%b busy=%b done=%b pass=%b ffv=%b cnt=%0d ffi=%0d required all zero",
               stim_a[0], sv_a[0], busy_a[0], done_a[0], pass_a[0], ffv_a[0], cnt_a[0], ffi_a[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (sv_a[0] !== 1'b0 || busy_a[0] !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL post_reset_idle: stim_valid/busy went high without start, required 0");
    end
    $display("[TB] midrun reset applied and released");
    run_check(0, 16'h0F0F, 32'h0, -1, "after_reset");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0;
      seed_a[d]  = 16'h0;
      fmask_a[d] = 32'h0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_latency();
    test_seed_zero();
    test_stop_on_fail();
    test_random();
    test_back_to_back();
    test_restart_ignored();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/equiv_checker.md
EQUIV_CHECKER -- requirements
Module: equiv_checker

Interface
REQ-001 Parameter IN_W, default 4, stimulus vector width, range 1..16.
REQ-002 Parameter OUT_W, default 2, width of each compared response, range 1..32.
REQ-003 Parameter N_VECTORS, default 10, number of vectors per run, range 1..65535.
REQ-004 Parameter LATENCY, default 0, cycles from stimulus to valid response, range 0..15.
REQ-005 Parameter STOP_ON_FAIL, default 0, 1 = abort the run on the first mismatch.
REQ-006 clk  input  1  single clock, all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 start  input  1  run request, sampled on the rising edge of clk.
REQ-009 seed  input  16  LFSR seed, captured on an accepted start.
REQ-010 stim  output  IN_W  vector driven identically to both units under test (UUTs).
REQ-011 stim_valid  output  1  stim holds a new vector this cycle.
REQ-012 resp_b  input  OUT_W  response of the behavioural UUT.
REQ-013 resp_s  input  OUT_W  response of the structural UUT.
REQ-014 busy  output  1  high in RUN or DRAIN.
REQ-015 done  output  1  high while in DONE.
REQ-016 pass  output  1  valid when done is high, 1 = zero mismatches.
REQ-017 mismatch_cnt  output  16  number of mismatching compares.
REQ-018 first_fail_idx  output  16  index of the first mismatching vector.
REQ-019 first_fail_valid  output  1  first_fail_idx holds a captured index.

Function
REQ-020 The block SHALL implement a four-state FSM with states IDLE, RUN, DRAIN and DONE.
REQ-021 A start sampled in IDLE or DONE SHALL load the LFSR with seed, or with 0xACE1 when seed==0, clear all counters and flags, and enter RUN.
REQ-022 A start sampled in RUN or DRAIN SHALL be ignored.
REQ-023 The LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400), and SHALL advance once per issued vector.
REQ-024 In RUN, the block SHALL register stim = lfsr[IN_W-1:0] with stim_valid=1, one vector per cycle; vector 0 SHALL be the loaded seed.
REQ-025 After vector N_VECTORS-1 is issued, the FSM SHALL enter DRAIN with stim_valid=0 and stim holding its last value.
REQ-026 A LATENCY-deep shift register of {valid, index} SHALL track vectors in flight.
REQ-027 Vector k SHALL be compared (resp_b != resp_s) exactly LATENCY cycles after the cycle in which stim_valid=1 carried vector k; LATENCY=0 compares in that same cycle.
REQ-028 On each mismatch, mismatch_cnt SHALL increment, saturating at 0xFFFF.
REQ-029 On the first mismatch only, first_fail_idx SHALL capture k and first_fail_valid SHALL be set.
REQ-030 DRAIN SHALL exit to DONE once the in-flight pipeline is empty; done SHALL first be high N_VECTORS+LATENCY+1 cycles after the start edge.
REQ-031 With STOP_ON_FAIL=1, a mismatch SHALL force stim_valid=0, flush the pipeline (no further compares), and enter DONE on the next edge.
REQ-032 In DONE, pass SHALL be (mismatch_cnt==0), and done, pass, the counters and first_fail_* SHALL hold until the next accepted start.
REQ-033 Compares SHALL occur only for pipeline entries that are valid; resp_b/resp_s SHALL be don't-care at all other times.

Reset
REQ-034 rst_n low SHALL immediately put the block in IDLE with stim=0, stim_valid=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, first_fail_valid=0, the pipeline cleared and the LFSR=0xACE1, including when rst_n falls mid-run.
REQ-035 After rst_n rises, the block SHALL require a fresh start before issuing any vector.

Verification
REQ-036 Defaults, resp_s tied to resp_b, seed=0x0001, start pulsed -> 10 stim_valid pulses, first stim=0x1, done high 11 cycles after start, pass=1, mismatch_cnt=0, first_fail_valid=0.
REQ-037 LATENCY=3, resp_s differs from resp_b for vector 3 only -> mismatch_cnt=1, first_fail_idx=3, first_fail_valid=1, pass=0, done 14 cycles after start.
REQ-038 seed=0x0000 -> first stim = 0xACE1[IN_W-1:0] (0x1 for IN_W=4), and the sequence matches a 0xB400 Galois reference model.
REQ-039 STOP_ON_FAIL=1, mismatch at vector 2, LATENCY=0 -> stim_valid low after vector 2, done on the next edge, mismatch_cnt=1.
REQ-040 start re-pulsed mid-RUN -> no restart and an unchanged vector count; rst_n pulsed low mid-RUN -> all outputs return to their reset values at once, and a later start runs the full 10 vectors.
